ad_mode_sequencer: RTL and testbench

AD_MODE_SEQUENCER -- requirements
Module: ad_mode_sequencer

---
 rtl/ad_light_pkg.sv | 38 +++
 rtl/step_prescaler.sv | 46 ++++
 rtl/ad_mode_sequencer.sv | 134 +++++++++++++
 tb/tb_ad_mode_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ad_light_pkg.sv
// Shared definitions for the light-show sequencer: state encoding, mode width,
// default auto-sequence range and small arithmetic helpers.
package ad_light_pkg;

  localparam int MODE_W       = 4;
  localparam int MODE_MIN_DEF = 1;
  localparam int MODE_MAX_DEF = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } seq_state_e;

  // Next mode in the auto sequence; anything outside [lo, hi] restarts at lo.
  function automatic logic [MODE_W-1:0] mode_advance(
    input logic [MODE_W-1:0] cur,
    input logic [MODE_W-1:0] lo,
    input logic [MODE_W-1:0] hi
  );
    if ((cur >= hi) || (cur < lo)) begin
      return lo;
    end else begin
      return cur + 4'd1;
    end
  endfunction

  // Prescaler terminal count for a given base divisor and speed shift.
  function automatic int unsigned term_count(
    input int unsigned div,
    input logic [1:0]  spd
  );
    int unsigned d;
    d = div >> spd;
    return (d == 32'd0) ? 32'd0 : d - 32'd1;
  endfunction

endpackage

// File: rtl/step_prescaler.sv
// Display-step prescaler: counts base clocks while running and strobes step_en
// once per (CLK_DIV >> speed) cycles; holds its count while not running.
module step_prescaler
  import ad_light_pkg::*;
#(
  parameter int unsigned CLK_DIV = 32'd25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       clr,
  input  logic [1:0] speed,
  output logic       tick,
  output logic       step_en
);

  localparam int CNT_W = (CLK_DIV > 32'd1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] term_s;

  // >= rather than == so a speed change that drops the terminal below the
  // current count still fires on the next cycle instead of wrapping around.
  assign term_s = CNT_W'(term_count(CLK_DIV, speed));
  assign tick   = run & ~clr & (cnt_r >= term_s);

  // Count, wrap on terminal and register the step strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= {CNT_W{1'b0}};
      step_en <= 1'b0;
    end else if (clr) begin
      cnt_r   <= {CNT_W{1'b0}};
      step_en <= 1'b0;
    end else if (tick) begin
      cnt_r   <= {CNT_W{1'b0}};
      step_en <= 1'b1;
    end else if (run) begin
      cnt_r   <= cnt_r + CNT_W'(1'b1);
      step_en <= 1'b0;
    end else begin
      step_en <= 1'b0;
    end
  end

endmodule

// File: rtl/ad_mode_sequencer.sv
// Mode sequencer for the LED pattern generator: IDLE/RUN/PAUSE control,
// dwell counting per mode and auto/manual mode advance.
module ad_mode_sequencer
  import ad_light_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 32'd25000000,
  parameter int unsigned DWELL_STEPS = 32'd32,
  parameter int unsigned MODE_MIN    = MODE_MIN_DEF,
  parameter int unsigned MODE_MAX    = MODE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_pulse,
  input  logic              pause_pulse,
  input  logic              next_pulse,
  input  logic              stop_pulse,
  input  logic [1:0]        speed,
  output logic [MODE_W-1:0] mode,
  output logic              step_en,
  output logic              mode_change,
  output logic [1:0]        state
);

  localparam int DW_W = (DWELL_STEPS > 32'd1) ? $clog2(DWELL_STEPS) : 1;
  localparam logic [DW_W-1:0]   DWELL_LAST = DW_W'(DWELL_STEPS - 32'd1);
  localparam logic [MODE_W-1:0] MODE_LO    = MODE_W'(MODE_MIN);
  localparam logic [MODE_W-1:0] MODE_HI    = MODE_W'(MODE_MAX);
  localparam logic [MODE_W-1:0] MODE_OFF   = {MODE_W{1'b0}};

  seq_state_e        state_r;
  logic [MODE_W-1:0] mode_r;
  logic              mode_change_r;
  logic [DW_W-1:0]   dwell_r;

  logic is_idle_s, is_run_s, is_pause_s, bad_state_s;
  logic start_act_s, pause_act_s, next_act_s;
  logic run_s, clr_s, tick_s;

  assign is_idle_s   = (state_r == ST_IDLE);
  assign is_run_s    = (state_r == ST_RUN);
  assign is_pause_s  = (state_r == ST_PAUSE);
  assign bad_state_s = ~(is_idle_s | is_run_s | is_pause_s);

  // Priority stop > start > pause > next, each only where it has an effect.
  assign start_act_s = ~stop_pulse & start_pulse & (is_idle_s | is_pause_s);
  assign pause_act_s = ~stop_pulse & pause_pulse & is_run_s;
  assign next_act_s  = ~stop_pulse & ~start_act_s & ~pause_act_s & next_pulse
                       & (is_run_s | is_pause_s);

  assign run_s = is_run_s & ~stop_pulse & ~pause_act_s & ~next_act_s;
  assign clr_s = stop_pulse | bad_state_s | next_act_s | (start_act_s & is_idle_s);

  step_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (run_s),
    .clr     (clr_s),
    .speed   (speed),
    .tick    (tick_s),
    .step_en (step_en)
  );

  // Control FSM with dwell counter and registered mode outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      mode_r        <= MODE_OFF;
      mode_change_r <= 1'b0;
      dwell_r       <= {DW_W{1'b0}};
    end else if (stop_pulse || bad_state_s) begin
      state_r       <= ST_IDLE;
      mode_r        <= MODE_OFF;
      mode_change_r <= 1'b0;
      dwell_r       <= {DW_W{1'b0}};
    end else begin
      mode_change_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_act_s) begin
            state_r       <= ST_RUN;
            mode_r        <= MODE_LO;
            mode_change_r <= 1'b1;
            dwell_r       <= {DW_W{1'b0}};
          end else begin
            mode_r  <= MODE_OFF;
            dwell_r <= {DW_W{1'b0}};
          end
        end
        ST_RUN: begin
          if (pause_act_s) begin
            state_r <= ST_PAUSE;
          end else if (next_act_s) begin
            mode_r        <= mode_advance(mode_r, MODE_LO, MODE_HI);
            mode_change_r <= 1'b1;
            dwell_r       <= {DW_W{1'b0}};
          end else if (tick_s) begin
            if (dwell_r == DWELL_LAST) begin
              mode_r        <= mode_advance(mode_r, MODE_LO, MODE_HI);
              mode_change_r <= 1'b1;
              dwell_r       <= {DW_W{1'b0}};
            end else begin
              dwell_r <= dwell_r + DW_W'(1'b1);
            end
          end else begin
            dwell_r <= dwell_r;
          end
        end
        ST_PAUSE: begin
          if (start_act_s) begin
            state_r <= ST_RUN;
          end else if (next_act_s) begin
            mode_r        <= mode_advance(mode_r, MODE_LO, MODE_HI);
            mode_change_r <= 1'b1;
            dwell_r       <= {DW_W{1'b0}};
          end else begin
            dwell_r <= dwell_r;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          mode_r  <= MODE_OFF;
          dwell_r <= {DW_W{1'b0}};
        end
      endcase
    end
  end

  assign mode        = mode_r;
  assign mode_change = mode_change_r;
  assign state       = state_r;

endmodule

// File: tb/tb_ad_mode_sequencer.sv
// Directed bench for ad_mode_sequencer with CLK_DIV=8, DWELL_STEPS=4.
module tb_ad_mode_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start_pulse, pause_pulse, next_pulse, stop_pulse;
  logic [1:0] speed;
  logic [3:0] mode;
  logic       step_en, mode_change;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  ad_mode_sequencer #(
    .CLK_DIV     (8),
    .DWELL_STEPS (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_pulse (start_pulse),
    .pause_pulse (pause_pulse),
    .next_pulse  (next_pulse),
    .stop_pulse  (stop_pulse),
    .speed       (speed),
    .mode        (mode),
    .step_en     (step_en),
    .mode_change (mode_change),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       st, pa, nx, sp;
    logic [1:0] spd;
    int         n;
    logic [1:0] e_state;
    logic [3:0] e_mode;
    logic       e_step, e_mc;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [1:0] es, input logic [3:0] em,
                     input logic estep, input logic emc);
    checks++;
    if (state !== es || mode !== em || step_en !== estep || mode_change !== emc) begin
      errors++;
      $display("FAIL %s: got state=%0d mode=%0d step_en=%0d mode_change=%0d, want state=%0d mode=%0d step_en=%0d mode_change=%0d",
               name, state, mode, step_en, mode_change, es, em, estep, emc);
    end
  endtask

  // Drive pulses for the first of n cycles; outputs sampled 1ns after each edge.
  task automatic run_row(input logic st, input logic pa, input logic nx, input logic sp,
                         input logic [1:0] spd, input int n);
    speed       = spd;
    start_pulse = st;
    pause_pulse = pa;
    next_pulse  = nx;
    stop_pulse  = sp;
    @(posedge clk); #1;
    start_pulse = 1'b0;
    pause_pulse = 1'b0;
    next_pulse  = 1'b0;
    stop_pulse  = 1'b0;
    for (int i = 1; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int steps;
    rst_n = 1'b0;
    start_pulse = 1'b0; pause_pulse = 1'b0; next_pulse = 1'b0; stop_pulse = 1'b0;
    speed = 2'd0;

    //           st pa nx sp spd  n  state mode step mc
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1, 2'd1, 4'd1, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 7, 2'd1, 4'd1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1, 2'd1, 4'd1, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8, 2'd1, 4'd1, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8, 2'd1, 4'd1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8, 2'd1, 4'd2, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1, 2'd1, 4'd2, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1, 2'd1, 4'd2, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1, 2'd2, 4'd2, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1, 2'd2, 4'd3, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1, 2'd1, 4'd3, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset", 2'd0, 4'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    run_row(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3);
    chk("idle_after_reset", 2'd0, 4'd0, 1'b0, 1'b0);

    for (int i = 0; i < 11; i++) begin
      run_row(vecs[i].st, vecs[i].pa, vecs[i].nx, vecs[i].sp, vecs[i].spd, vecs[i].n);
      chk($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_mode, vecs[i].e_step, vecs[i].e_mc);
    end

    // Manual advance up to mode 12, then auto wrap back to mode 1.
    for (int i = 0; i < 9; i++) begin
      run_row(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1);
      chk($sformatf("next_to_%0d", 4 + i), 2'd1, 4'(4 + i), 1'b0, 1'b1);
    end
    run_row(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 31);
    chk("mode12_hold", 2'd1, 4'd12, 1'b0, 1'b0);
    run_row(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1);
    chk("wrap_to_1", 2'd1, 4'd1, 1'b1, 1'b1);

    // Speed 2 (divisor 2) then speed 3 (divisor 1).
    run_row(1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1);
    chk("spd2_next", 2'd1, 4'd2, 1'b0, 1'b1);
    run_row(1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1);
    chk("spd2_e1", 2'd1, 4'd2, 1'b0, 1'b0);
    run_row(1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1);
    chk("spd2_e2", 2'd1, 4'd2, 1'b1, 1'b0);
    run_row(1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1);
    chk("spd2_e3", 2'd1, 4'd2, 1'b0, 1'b0);
    run_row(1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1);
    chk("spd2_e4", 2'd1, 4'd2, 1'b1, 1'b0);
    run_row(1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1);
    chk("spd3_e1", 2'd1, 4'd2, 1'b1, 1'b0);
    run_row(1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1);
    chk("spd3_e2", 2'd1, 4'd3, 1'b1, 1'b1);
    run_row(1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1);
    chk("spd3_e3", 2'd1, 4'd3, 1'b1, 1'b0);

    // Lowering the terminal below the current count fires on the next cycle.
    run_row(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 7);
    chk("cnt6_spd0", 2'd1, 4'd4, 1'b0, 1'b0);
    run_row(1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1);
    chk("speed_drop_fire", 2'd1, 4'd4, 1'b1, 1'b0);

    // Pause with prescaler at 5, hold 20 cycles, resume.
    run_row(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 6);
    chk("cnt5", 2'd1, 4'd5, 1'b0, 1'b0);
    run_row(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1);
    chk("paused", 2'd2, 4'd5, 1'b0, 1'b0);
    steps = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (step_en !== 1'b0 || state !== 2'd2) steps++;
    end
    checks++;
    if (steps != 0) begin
      errors++;
      $display("FAIL pause_hold: got %0d cycles with step_en or non-PAUSE state, want 0", steps);
    end
    run_row(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1);
    chk("resume", 2'd1, 4'd5, 1'b0, 1'b0);
    run_row(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1);
    chk("resume_e1", 2'd1, 4'd5, 1'b0, 1'b0);
    run_row(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1);
    chk("resume_e2", 2'd1, 4'd5, 1'b0, 1'b0);
    run_row(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1);
    chk("resume_e3", 2'd1, 4'd5, 1'b1, 1'b0);

    // Stop beats next; pulses other than start are ignored in IDLE.
    run_row(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1);
    chk("stop_next", 2'd0, 4'd0, 1'b0, 1'b0);
    run_row(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1);
    chk("idle_pause", 2'd0, 4'd0, 1'b0, 1'b0);
    run_row(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1);
    chk("idle_next", 2'd0, 4'd0, 1'b0, 1'b0);

    // next on the dwell-expiry cycle advances exactly once and clears dwell.
    run_row(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1);
    chk("start_over_pause", 2'd1, 4'd1, 1'b0, 1'b1);
    run_row(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 24);
    chk("third_step", 2'd1, 4'd1, 1'b1, 1'b0);
    run_row(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 7);
    chk("pre_expiry", 2'd1, 4'd1, 1'b0, 1'b0);
    run_row(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1);
    chk("next_on_expiry", 2'd1, 4'd2, 1'b0, 1'b1);
    run_row(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 31);
    chk("dwell_cleared", 2'd1, 4'd2, 1'b0, 1'b0);
    run_row(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1);
    chk("full_dwell_adv", 2'd1, 4'd3, 1'b1, 1'b1);

    // Asynchronous reset mid-RUN; no restart without start.
    rst_n = 1'b0;
    #1;
    chk("async_reset", 2'd0, 4'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_row(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 10);
    chk("stay_idle", 2'd0, 4'd0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
